// File: rtl/commutatore_8vie_nbit_rr_if.sv
// Bus bundle for the 8-way commutator: eight request/ack/data sources and one buffered
// valid/ready output toward the consumer.
interface commutatore_8vie_nbit_rr_if #(
    parameter int unsigned N = 31
);
    logic [N-1:0] x1, x2, x3, x4, x5, x6, x7, x8;
    logic         rdy1, rdy2, rdy3, rdy4, rdy5, rdy6, rdy7, rdy8;
    logic         ack1, ack2, ack3, ack4, ack5, ack6, ack7, ack8;
    logic [N-1:0] z;
    logic [2:0]   alpha_out;
    logic         z_valid;
    logic         z_ready;

    // Commutator side.
    modport master (
        input  x1, x2, x3, x4, x5, x6, x7, x8,
        input  rdy1, rdy2, rdy3, rdy4, rdy5, rdy6, rdy7, rdy8,
        input  z_ready,
        output ack1, ack2, ack3, ack4, ack5, ack6, ack7, ack8,
        output z, alpha_out, z_valid
    );

    // Sources and consumer side.
    modport slave (
        output x1, x2, x3, x4, x5, x6, x7, x8,
        output rdy1, rdy2, rdy3, rdy4, rdy5, rdy6, rdy7, rdy8,
        output z_ready,
        input  ack1, ack2, ack3, ack4, ack5, ack6, ack7, ack8,
        input  z, alpha_out, z_valid
    );
endinterface

// File: rtl/commutatore_8vie_nbit_rr.sv
// 8-way commutator: round-robin grant of eight N-bit sources into a one-entry output buffer.
// Define COMM8_FIXED_PRIO_EN for fixed priority (source 1 highest) with no rotation pointer.
module commutatore_8vie_nbit_rr #(
    parameter int unsigned N = 31
) (
    input logic                          clock,
    input logic                          reset_n,
    commutatore_8vie_nbit_rr_if.master   bus_io
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e       state_q, state_d;
    logic [N-1:0] z_q, z_d;
    logic [2:0]   alpha_q, alpha_d;

    logic [7:0]   rdy;
    logic [N-1:0] x [8];
    logic [2:0]   grant_idx;
    logic         load;
    logic [7:0]   ack;

    assign rdy = {bus_io.rdy8, bus_io.rdy7, bus_io.rdy6, bus_io.rdy5,
                  bus_io.rdy4, bus_io.rdy3, bus_io.rdy2, bus_io.rdy1};

    assign x[0] = bus_io.x1;
    assign x[1] = bus_io.x2;
    assign x[2] = bus_io.x3;
    assign x[3] = bus_io.x4;
    assign x[4] = bus_io.x5;
    assign x[5] = bus_io.x6;
    assign x[6] = bus_io.x7;
    assign x[7] = bus_io.x8;

`ifdef COMM8_FIXED_PRIO_EN
    // Lowest requesting index wins.
    always_comb begin
        grant_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rdy[i]) grant_idx = 3'(i);
        end
    end
`else
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] cand;
    logic       found;

    // Scan ptr, ptr+1, ... ptr+7; the 3-bit add provides the mod-8 wrap.
    always_comb begin
        grant_idx = ptr_q;
        found     = 1'b0;
        cand      = ptr_q;
        for (int unsigned i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && rdy[cand]) begin
                grant_idx = cand;
                found     = 1'b1;
            end
        end
    end
`endif

    // Gating with reset_n keeps every ack low while reset is asserted.
    assign load = reset_n & (|rdy) & ((state_q == StEmpty) | bus_io.z_ready);
    assign ack  = load ? (8'b1 << grant_idx) : 8'b0;

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        alpha_d = alpha_q;
`ifndef COMM8_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            state_d = StFull;
            z_d     = x[grant_idx];
            alpha_d = grant_idx;
`ifndef COMM8_FIXED_PRIO_EN
            ptr_d   = grant_idx + 3'd1;
`endif
        end else if (state_q == StFull && bus_io.z_ready) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StEmpty;
            z_q     <= '0;
            alpha_q <= 3'd0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            alpha_q <= alpha_d;
        end
    end

`ifndef COMM8_FIXED_PRIO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign bus_io.z         = z_q;
    assign bus_io.alpha_out = alpha_q;
    assign bus_io.z_valid   = (state_q == StFull);

    assign bus_io.ack1 = ack[0];
    assign bus_io.ack2 = ack[1];
    assign bus_io.ack3 = ack[2];
    assign bus_io.ack4 = ack[3];
    assign bus_io.ack5 = ack[4];
    assign bus_io.ack6 = ack[5];
    assign bus_io.ack7 = ack[6];
    assign bus_io.ack8 = ack[7];

endmodule

// File: tb/tb_commutatore_8vie_nbit_rr.sv
// Directed table-driven bench for commutatore_8vie_nbit_rr plus reset and rotation sequences.
module tb_commutatore_8vie_nbit_rr;

    localparam int unsigned N = 31;

    logic clock;
    logic reset_n;

    commutatore_8vie_nbit_rr_if #(.N(N)) bus ();

    commutatore_8vie_nbit_rr #(.N(N)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus_io  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [7:0]   rdy;
        logic         zr;
        logic [7:0]   ack;
        logic         valid;
        logic [2:0]   alpha;
        logic [N-1:0] z;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    logic [N-1:0] xv [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic set_in(input logic [7:0] r, input logic zr);
        bus.rdy1 = r[0]; bus.rdy2 = r[1]; bus.rdy3 = r[2]; bus.rdy4 = r[3];
        bus.rdy5 = r[4]; bus.rdy6 = r[5]; bus.rdy7 = r[6]; bus.rdy8 = r[7];
        bus.z_ready = zr;
    endtask

    function automatic logic [7:0] get_ack();
        return {bus.ack8, bus.ack7, bus.ack6, bus.ack5, bus.ack4, bus.ack3, bus.ack2, bus.ack1};
    endfunction

    // One clock: ack checked before the edge, registered outputs just after it.
    task automatic cycle(input string tag, input logic [7:0] r, input logic zr,
                         input logic [7:0] eack, input logic ev, input logic [2:0] ea,
                         input logic [N-1:0] ez);
        set_in(r, zr);
        #2;
        chk({tag, " ack"}, 64'(get_ack()), 64'(eack));
        @(posedge clock);
        #1;
        chk({tag, " z_valid"}, 64'(bus.z_valid), 64'(ev));
        chk({tag, " alpha_out"}, 64'(bus.alpha_out), 64'(ea));
        chk({tag, " z"}, 64'(bus.z), 64'(ez));
    endtask

    vec_t tbl [21];

    initial begin
        xv[0] = 31'h1111; xv[1] = 31'h2222; xv[2] = 31'h1234; xv[3] = 31'h4444;
        xv[4] = 31'h5555; xv[5] = 31'h6666; xv[6] = 31'h7777; xv[7] = 31'h0888;
        bus.x1 = xv[0]; bus.x2 = xv[1]; bus.x3 = xv[2]; bus.x4 = xv[3];
        bus.x5 = xv[4]; bus.x6 = xv[5]; bus.x7 = xv[6]; bus.x8 = xv[7];

        // Continuous sequence from reset: ptr=0, buffer empty.
        tbl[0]  = '{8'h04, 1'b1, 8'h04, 1'b1, 3'd2, 31'h1234}; // rdy3 -> ptr=3
        tbl[1]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd2, 31'h1234}; // drain, z holds
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd2, 31'h1234}; // idle
        tbl[3]  = '{8'hff, 1'b1, 8'h08, 1'b1, 3'd3, 31'h4444}; // ptr=3 -> src4
        tbl[4]  = '{8'hff, 1'b1, 8'h10, 1'b1, 3'd4, 31'h5555};
        tbl[5]  = '{8'hff, 1'b1, 8'h20, 1'b1, 3'd5, 31'h6666};
        tbl[6]  = '{8'hff, 1'b1, 8'h40, 1'b1, 3'd6, 31'h7777};
        tbl[7]  = '{8'hff, 1'b1, 8'h80, 1'b1, 3'd7, 31'h0888};
        tbl[8]  = '{8'hff, 1'b1, 8'h01, 1'b1, 3'd0, 31'h1111}; // wrap 7->0
        tbl[9]  = '{8'hff, 1'b1, 8'h02, 1'b1, 3'd1, 31'h2222};
        tbl[10] = '{8'hff, 1'b0, 8'h00, 1'b1, 3'd1, 31'h2222}; // backpressure
        tbl[11] = '{8'h10, 1'b0, 8'h00, 1'b1, 3'd1, 31'h2222};
        tbl[12] = '{8'h10, 1'b0, 8'h00, 1'b1, 3'd1, 31'h2222};
        tbl[13] = '{8'h10, 1'b1, 8'h10, 1'b1, 3'd4, 31'h5555}; // drain+refill
        tbl[14] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 31'h0888}; // ptr=5 -> src8
        tbl[15] = '{8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 31'h1111}; // ptr=0 -> src1
        tbl[16] = '{8'h81, 1'b1, 8'h80, 1'b1, 3'd7, 31'h0888}; // ptr=1 -> src8
        tbl[17] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 31'h0888};
        tbl[18] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 31'h0888};
        tbl[19] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 31'h0888}; // z_ready while empty
        tbl[20] = '{8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 31'h2222}; // empty loads despite !z_ready

        reset_n = 1'b0;
        set_in(8'hff, 1'b1);
        #12;
        chk("reset ack", 64'(get_ack()), 64'h0);
        chk("reset z_valid", 64'(bus.z_valid), 64'h0);
        chk("reset alpha_out", 64'(bus.alpha_out), 64'h0);
        chk("reset z", 64'(bus.z), 64'h0);
        set_in(8'h00, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

`ifndef COMM8_FIXED_PRIO_EN
        for (int i = 0; i < 21; i++) begin
            cycle($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].zr, tbl[i].ack,
                  tbl[i].valid, tbl[i].alpha, tbl[i].z);
        end

        // Async reset while FULL with a pending grant (ptr=2 -> src3).
        set_in(8'hff, 1'b1);
        #2;
        chk("pre-reset ack", 64'(get_ack()), 64'h04);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async ack", 64'(get_ack()), 64'h0);
        chk("async z_valid", 64'(bus.z_valid), 64'h0);
        chk("async alpha_out", 64'(bus.alpha_out), 64'h0);
        chk("async z", 64'(bus.z), 64'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // All sources requesting: order restarts at source 1 after reset.
        for (int i = 0; i < 16; i++) begin
            cycle($sformatf("rr%0d", i), 8'hff, 1'b1, 8'(8'h01 << (i % 8)), 1'b1,
                  3'(i % 8), xv[i % 8]);
        end
`else
        for (int i = 0; i < 8; i++) begin
            cycle($sformatf("fixed%0d", i), 8'h42, 1'b1, 8'h02, 1'b1, 3'd1, xv[1]);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
